// File: rtl/card_grid_pkg.sv
// rtl/card_grid_pkg.sv - shared types and colours for the memory-game card grid renderer
package card_grid_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [2:0] {
        DOWN      = 3'd0,
        FLIP_UP_S = 3'd1,
        UP        = 3'd2,
        FLIP_DN_S = 3'd3,
        MATCHED   = 3'd4
    } card_state_t;

    typedef enum logic [1:0] {
        OP_SET_SYM   = 2'd0,
        OP_FLIP_UP   = 2'd1,
        OP_FLIP_DOWN = 2'd2,
        OP_MATCH     = 2'd3
    } cmd_op_t;

    localparam logic [23:0] C_BG     = 24'h000000;
    localparam logic [23:0] C_BACK   = 24'h0000FF;
    localparam logic [23:0] C_FACE   = 24'hFFFFFF;
    localparam logic [23:0] C_GLYPH  = 24'hFF0000;
    localparam logic [23:0] C_FLIP   = 24'h808080;
    localparam logic [23:0] C_MATCH  = 24'h00C000;
    localparam logic [23:0] C_CURSOR = 24'hFFFF00;

endpackage

// File: rtl/card_glyph.sv
// rtl/card_glyph.sv - combinational symbol shapes drawn around the card centre
module card_glyph
    import card_grid_pkg::*;
#(
    parameter int CARD_W = 50,
    parameter int CARD_H = 70,
    parameter int NSYM   = 8
) (
    input  logic [COORD_W-1:0]      lx,
    input  logic [COORD_W-1:0]      ly,
    input  logic [$clog2(NSYM)-1:0] sym,
    output logic                    in_glyph
);

    int dx;
    int dy;
    int adx;
    int ady;
    logic [2:0] shape;

    always_comb begin
        dx    = int'(lx) - CARD_W / 2;
        dy    = int'(ly) - CARD_H / 2;
        adx   = (dx < 0) ? -dx : dx;
        ady   = (dy < 0) ? -dy : dy;
        // symbols beyond eight reuse the base shapes
        shape = 3'(32'(sym) % 32'd8);
        case (shape)
            3'd0:    in_glyph = (adx < 10) && (ady < 10);
            3'd1:    in_glyph = (adx + ady) < 12;
            3'd2:    in_glyph = (ady < 4) && (adx < 14);
            3'd3:    in_glyph = (adx < 4) && (ady < 18);
            3'd4:    in_glyph = ((ady < 4) && (adx < 14)) || ((adx < 4) && (ady < 18));
            3'd5:    in_glyph = ((adx - ady) < 3) && ((ady - adx) < 3) && (adx < 12);
            3'd6:    in_glyph = (adx < 12) && (ady < 12) && !((adx < 7) && (ady < 7));
            default: in_glyph = (dy >= -12) && (dy < 12) && ((2 * adx) <= (dy + 12));
        endcase
    end

endmodule

// File: rtl/card_grid_renderer.sv
// rtl/card_grid_renderer.sv - card grid state holder and two-stage pixel colour pipeline
module card_grid_renderer
    import card_grid_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int ORIGIN_X    = 160,
    parameter int ORIGIN_Y    = 70,
    parameter int CARD_W      = 50,
    parameter int CARD_H      = 70,
    parameter int PITCH_X     = 90,
    parameter int PITCH_Y     = 90,
    parameter int NSYM        = 8,
    parameter int FLIP_FRAMES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     x,
    input  logic [9:0]                     y,
    input  logic                           video_on,
    input  logic                           frame_start,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [$clog2(ROWS*COLS)-1:0]   cmd_idx,
    input  logic [$clog2(NSYM)-1:0]        cmd_sym,
    input  logic [$clog2(ROWS*COLS)-1:0]   cursor_idx,
    output logic [7:0]                     r,
    output logic [7:0]                     g,
    output logic [7:0]                     b
);

    localparam int NCARD = ROWS * COLS;
    localparam int IDX_W = $clog2(NCARD);
    localparam int SYM_W = $clog2(NSYM);
    localparam int CNT_W = $clog2(FLIP_FRAMES + 1);

    card_state_t      card_state [NCARD];
    logic [SYM_W-1:0] card_sym   [NCARD];
    logic [CNT_W-1:0] anim_cnt;
    logic [IDX_W-1:0] anim_idx;

    logic    accept;
    logic    idx_ok;
    cmd_op_t op;

    assign cmd_ready = !rst && (anim_cnt == '0);
    assign accept    = cmd_valid && cmd_ready;
    assign idx_ok    = 32'(cmd_idx) < NCARD;
    assign op        = cmd_op_t'(cmd_op);

    // a load can only happen with the counter idle, so it always wins over a decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCARD; i++) begin
                card_state[i] <= DOWN;
                card_sym[i]   <= '0;
            end
            anim_cnt <= '0;
            anim_idx <= '0;
        end else if (accept) begin
            if (idx_ok) begin
                case (op)
                    OP_SET_SYM: card_sym[cmd_idx] <= cmd_sym;
                    OP_FLIP_UP: begin
                        if (card_state[cmd_idx] == DOWN) begin
                            card_state[cmd_idx] <= FLIP_UP_S;
                            anim_cnt            <= CNT_W'(FLIP_FRAMES);
                            anim_idx            <= cmd_idx;
                        end
                    end
                    OP_FLIP_DOWN: begin
                        if (card_state[cmd_idx] == UP) begin
                            card_state[cmd_idx] <= FLIP_DN_S;
                            anim_cnt            <= CNT_W'(FLIP_FRAMES);
                            anim_idx            <= cmd_idx;
                        end
                    end
                    default: begin
                        if (card_state[cmd_idx] == UP) card_state[cmd_idx] <= MATCHED;
                    end
                endcase
            end
        end else if (frame_start && (anim_cnt != '0)) begin
            anim_cnt <= anim_cnt - 1'b1;
            if (anim_cnt == CNT_W'(1)) begin
                case (card_state[anim_idx])
                    FLIP_UP_S: card_state[anim_idx] <= UP;
                    FLIP_DN_S: card_state[anim_idx] <= DOWN;
                    default:   ;
                endcase
            end
        end
    end

    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;
    logic [COORD_W-1:0] lx_c, ly_c, px, py, left, top;

    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        lx_c  = '0;
        ly_c  = '0;
        left  = '0;
        top   = '0;
        px    = {1'b0, x};
        py    = {1'b0, y};
        for (int rr = 0; rr < ROWS; rr++) begin
            for (int cc = 0; cc < COLS; cc++) begin
                left = COORD_W'(ORIGIN_X + cc * PITCH_X);
                top  = COORD_W'(ORIGIN_Y + rr * PITCH_Y);
                if (px >= left && px < left + COORD_W'(CARD_W) &&
                    py >= top  && py < top  + COORD_W'(CARD_H)) begin
                    hit_c = 1'b1;
                    idx_c = IDX_W'(rr * COLS + cc);
                    lx_c  = px - left;
                    ly_c  = py - top;
                end
            end
        end
    end

    logic               s1_hit;
    logic               s1_vid;
    logic [IDX_W-1:0]   s1_idx;
    logic [COORD_W-1:0] s1_lx, s1_ly;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit <= 1'b0;
            s1_vid <= 1'b0;
            s1_idx <= '0;
            s1_lx  <= '0;
            s1_ly  <= '0;
        end else begin
            s1_hit <= hit_c;
            s1_vid <= video_on;
            s1_idx <= idx_c;
            s1_lx  <= lx_c;
            s1_ly  <= ly_c;
        end
    end

    card_state_t cur_state;
    logic        in_glyph;
    logic        border;
    logic [23:0] pix;

    assign cur_state = card_state[s1_idx];
    assign border    = (s1_lx < COORD_W'(2)) || (s1_lx >= COORD_W'(CARD_W - 2)) ||
                       (s1_ly < COORD_W'(2)) || (s1_ly >= COORD_W'(CARD_H - 2));

    card_glyph #(
        .CARD_W(CARD_W),
        .CARD_H(CARD_H),
        .NSYM  (NSYM)
    ) u_glyph (
        .lx      (s1_lx),
        .ly      (s1_ly),
        .sym     (card_sym[s1_idx]),
        .in_glyph(in_glyph)
    );

    always_comb begin
        pix = C_BG;
        if (!s1_vid || !s1_hit) begin
            pix = C_BG;
        end else if ((s1_idx == cursor_idx) && border) begin
            pix = C_CURSOR;
        end else begin
            case (cur_state)
                DOWN:                 pix = C_BACK;
                FLIP_UP_S, FLIP_DN_S: pix = C_FLIP;
                UP:                   pix = in_glyph ? C_GLYPH : C_FACE;
                MATCHED:              pix = in_glyph ? C_FACE : C_MATCH;
                default:              pix = C_BG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) {r, g, b} <= 24'h000000;
        else     {r, g, b} <= pix;
    end

endmodule

// File: tb/tb_card_grid_renderer.sv
// tb/tb_card_grid_renderer.sv - scoreboard bench for card_grid_renderer (4x4 and 2x3 instances)
module tb_card_grid_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = '0, y = '0;
    logic       video_on = 1'b1, frame_start = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_sym = '0;
    logic       valid1 = 1'b0, valid2 = 1'b0;
    logic [3:0] idx1 = '0, cursor1 = 4'd5;
    logic [2:0] idx2 = '0, cursor2 = 3'd0;
    logic       ready1, ready2;
    logic [7:0] r1, g1, b1, r2, g2, b2;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [23:0] colour;
        int          sel;
        string       name;
    } exp_t;
    exp_t sb[$];
    exp_t cur;
    logic [23:0] act;

    logic probe_q = 1'b0;
    logic p1 = 1'b0, p2 = 1'b0;

    always #5 clk = ~clk;

    card_grid_renderer dut1 (
        .clk(clk), .rst(rst), .x(x), .y(y), .video_on(video_on), .frame_start(frame_start),
        .cmd_valid(valid1), .cmd_ready(ready1), .cmd_op(cmd_op), .cmd_idx(idx1),
        .cmd_sym(cmd_sym), .cursor_idx(cursor1), .r(r1), .g(g1), .b(b1)
    );

    card_grid_renderer #(.ROWS(2), .COLS(3)) dut2 (
        .clk(clk), .rst(rst), .x(x), .y(y), .video_on(video_on), .frame_start(frame_start),
        .cmd_valid(valid2), .cmd_ready(ready2), .cmd_op(cmd_op), .cmd_idx(idx2),
        .cmd_sym(cmd_sym), .cursor_idx(cursor2), .r(r2), .g(g2), .b(b2)
    );

    always @(posedge clk) begin
        p1 <= probe_q;
        p2 <= p1;
    end

    always @(negedge clk) begin
        if (p2) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL scoreboard_empty: pixel output with no expectation queued");
            end else begin
                cur = sb.pop_front();
                act = (cur.sel == 0) ? {r1, g1, b1} : {r2, g2, b2};
                if (act !== cur.colour) begin
                    mismatched++;
                    $display("FAIL %s: got %06h expected %06h", cur.name, act, cur.colour);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, actual, expected);
        end
    endtask

    task automatic probe(input int sel, input int px, input int py, input logic vid,
                         input logic [23:0] exp_c, input string nm);
        @(negedge clk);
        x        = 10'(px);
        y        = 10'(py);
        video_on = vid;
        probe_q  = 1'b1;
        sb.push_back('{exp_c, sel, nm});
        @(negedge clk);
        probe_q  = 1'b0;
        video_on = 1'b1;
    endtask

    task automatic send(input int sel, input logic [1:0] op, input int idx,
                        input logic [2:0] sym, input logic fs);
        int n;
        @(negedge clk);
        cmd_op      = op;
        cmd_sym     = sym;
        frame_start = fs;
        if (sel == 0) begin valid1 = 1'b1; idx1 = 4'(idx); end
        else          begin valid2 = 1'b1; idx2 = 3'(idx); end
        n = 0;
        while (((sel == 0) ? !ready1 : !ready2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            compared++;
            mismatched++;
            $display("FAIL cmd_timeout: ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        valid1      = 1'b0;
        valid2      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(ready1), 32'd0);
        chk("rgb_in_reset", 32'({r1, g1, b1}), 32'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(ready1), 32'd1);

        probe(0, 170, 80, 1'b1, 24'h0000FF, "down_170_80");
        probe(0, 170, 80, 1'b0, 24'h000000, "video_off");
        probe(0, 250, 195, 1'b1, 24'hFFFF00, "cursor_lx0");
        probe(0, 252, 195, 1'b1, 24'h0000FF, "cursor_lx2");
        probe(0, 299, 195, 1'b1, 24'hFFFF00, "cursor_lx49");
        probe(0, 170, 250, 1'b1, 24'h0000FF, "row2_4x4");

        send(0, 2'd0, 0, 3'd2, 1'b0);
        send(0, 2'd1, 0, 3'd0, 1'b1);
        chk("ready_drop", 32'(ready1), 32'd0);
        probe(0, 185, 105, 1'b1, 24'h808080, "flipping");
        pulse(7);
        probe(0, 185, 105, 1'b1, 24'h808080, "flip_after_7");
        chk("ready_after_7", 32'(ready1), 32'd0);
        pulse(1);
        probe(0, 185, 105, 1'b1, 24'hFF0000, "up_glyph");
        probe(0, 185, 110, 1'b1, 24'hFFFFFF, "up_face_sym2");
        chk("ready_after_8", 32'(ready1), 32'd1);

        send(0, 2'd3, 1, 3'd0, 1'b0);
        chk("ready_after_match_down", 32'(ready1), 32'd1);
        probe(0, 275, 105, 1'b1, 24'h0000FF, "match_on_down");

        send(0, 2'd1, 3, 3'd0, 1'b0);
        pulse(8);
        send(0, 2'd3, 3, 3'd0, 1'b0);
        probe(0, 455, 105, 1'b1, 24'hFFFFFF, "matched_glyph");
        probe(0, 435, 75, 1'b1, 24'h00C000, "matched_card");

        send(0, 2'd2, 0, 3'd0, 1'b0);
        probe(0, 185, 105, 1'b1, 24'h808080, "flipping_down");
        pulse(3);
        @(negedge clk);
        rst = 1'b1;
        probe(0, 185, 105, 1'b1, 24'h000000, "rgb_during_reset");
        chk("ready_during_reset", 32'(ready1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_midreset", 32'(ready1), 32'd1);
        probe(0, 185, 105, 1'b1, 24'h0000FF, "down_after_reset");
        probe(0, 455, 105, 1'b1, 24'h0000FF, "match_cleared");

        send(1, 2'd1, 6, 3'd0, 1'b0);
        chk("oob_ignored", 32'(ready2), 32'd1);
        probe(1, 339, 100, 1'b1, 24'h000000, "x_left_minus1");
        probe(1, 340, 100, 1'b1, 24'h0000FF, "x_left");
        probe(1, 389, 100, 1'b1, 24'h0000FF, "x_right_in");
        probe(1, 390, 100, 1'b1, 24'h000000, "x_right_out");
        probe(1, 170, 250, 1'b1, 24'h000000, "row2_2x3");

        repeat (6) @(negedge clk);
        if (sb.size() != 0) begin
            compared += sb.size();
            mismatched += sb.size();
            $display("FAIL scoreboard_leftover: %0d expectations never matched, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
